// File: rtl/p18_pkg.sv
// ============================================================================
// Module      : p18_pkg
// Description : Shared types and defaults for the block-state arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package p18_pkg;

  localparam int NUM_ROWS   = 15;
  localparam int LINE_WIDTH = 13;
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic                  wr;
    logic                  sh;
    logic [LINE_WIDTH-1:0] data;
  } host_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    REALIGN = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/p18_op_fifo.sv
// ============================================================================
// Module      : p18_op_fifo
// Description : Small synchronous FIFO for queued host ops, with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module p18_op_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_last
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_last  = (r_count == CW'(1));
  assign o_rdata = r_mem[r_rd_ptr];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/p18_block_state_arbiter.sv
// ============================================================================
// Module      : p18_block_state_arbiter
// Description : Shares block-state storage between video and queued host ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module p18_block_state_arbiter #(
  parameter int NUM_ROWS   = p18_pkg::NUM_ROWS,
  parameter int LINE_WIDTH = p18_pkg::LINE_WIDTH,
  parameter int FIFO_DEPTH = p18_pkg::FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic                        vactive,
  input  logic                        reset_state,
  input  logic                        vid_next_line,
  input  logic                        vid_write_line,
  input  logic [LINE_WIDTH-1:0]       vid_new_line,
  input  logic                        spi_start,
  input  logic                        spi_write_line,
  input  logic                        spi_shift_line,
  input  logic [LINE_WIDTH-1:0]       spi_new_line,
  output logic                        st_next_line,
  output logic                        st_write_line,
  output logic [LINE_WIDTH-1:0]       st_new_line,
  output logic                        spi_busy,
  output logic                        spi_overflow,
  output logic [$clog2(NUM_ROWS)-1:0] head_row
);

  import p18_pkg::*;

  localparam int              HW         = $clog2(NUM_ROWS);
  localparam int              OW         = $bits(host_op_t);
  localparam logic [HW-1:0]   c_last_row = HW'(NUM_ROWS - 1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [HW-1:0] r_head_row;
  logic          r_overflow;

  host_op_t      w_push_op;
  host_op_t      w_head_op;
  logic [OW-1:0] w_fifo_rdata;
  logic          w_fifo_push;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_fifo_last;

  logic          w_window;
  logic          w_vid_req;
  logic          w_host_ok;
  logic          w_issue;
  logic          w_realign;
  logic          w_drop;

  assign w_push_op   = {spi_write_line, spi_shift_line, spi_new_line};
  assign w_fifo_push = (spi_write_line | spi_shift_line) & ~reset_state;
  assign w_head_op   = host_op_t'(w_fifo_rdata);

  assign w_window  = ~vactive;
  assign w_vid_req = vid_next_line | vid_write_line;
  assign w_host_ok = w_window & ~w_vid_req & ~reset_state;

  p18_op_fifo #(
    .WIDTH (OW),
    .DEPTH (FIFO_DEPTH)
  ) u_op_fifo (
    .clk     (clk),
    .nRst    (nRst),
    .i_flush (reset_state),
    .i_push  (w_fifo_push),
    .i_pop   (w_issue),
    .i_wdata (w_push_op),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_last  (w_fifo_last)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // IDLE acts in the same cycle the window opens, so no open cycle is wasted.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_realign   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_window && !reset_state) begin
          if (!w_fifo_empty) begin
            w_issue     = w_host_ok;
            w_state_nxt = (w_issue && w_fifo_last && !w_fifo_push) ? IDLE : ISSUE;
          end else if (r_head_row != '0) begin
            w_realign   = w_host_ok;
            w_state_nxt = (w_realign && r_head_row == c_last_row) ? IDLE : REALIGN;
          end
        end
      end
      ISSUE: begin
        if (!w_window || w_fifo_empty) begin
          w_state_nxt = IDLE;
        end else begin
          w_issue = w_host_ok;
          if (w_issue && w_fifo_last && !w_fifo_push) begin
            w_state_nxt = IDLE;
          end
        end
      end
      REALIGN: begin
        if (!w_window || r_head_row == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_realign = w_host_ok;
          if (w_realign && r_head_row == c_last_row) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (reset_state) begin
      w_state_nxt = IDLE;
    end
  end

  always_comb begin
    st_next_line  = 1'b0;
    st_write_line = 1'b0;
    st_new_line   = '0;
    if (!nRst) begin
      st_next_line = 1'b0;
    end else if (w_vid_req) begin
      st_next_line  = vid_next_line;
      st_write_line = vid_write_line;
      st_new_line   = vid_new_line;
    end else if (w_issue) begin
      st_next_line  = w_head_op.sh;
      st_write_line = w_head_op.wr;
      st_new_line   = w_head_op.data;
    end else if (w_realign) begin
      st_next_line = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_head_row <= '0;
    end else if (reset_state) begin
      r_head_row <= '0;
    end else if (st_next_line) begin
      r_head_row <= (r_head_row == c_last_row) ? '0 : r_head_row + HW'(1);
    end
  end

  assign w_drop = w_fifo_push & w_fifo_full & ~w_issue;

  // An overflow in the same cycle as spi_start wins, so the drop is never hidden.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (spi_start) begin
      r_overflow <= 1'b0;
    end
  end

  assign spi_busy     = ~w_fifo_empty | (r_state != IDLE);
  assign spi_overflow = r_overflow;
  assign head_row     = r_head_row;

endmodule

`default_nettype wire

// File: tb/tb_p18_block_state_arbiter.sv
// ============================================================================
// Module      : tb_p18_block_state_arbiter
// Description : Scenario-driven self-checking bench with a host-op scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_p18_block_state_arbiter;

  localparam int LW = 13;
  localparam int HW = 4;

  typedef struct packed {
    logic          wr;
    logic          sh;
    logic [LW-1:0] data;
  } exp_op_t;

  logic          clk = 1'b0;
  logic          nRst;
  logic          vactive;
  logic          reset_state;
  logic          vid_next_line;
  logic          vid_write_line;
  logic [LW-1:0] vid_new_line;
  logic          spi_start;
  logic          spi_write_line;
  logic          spi_shift_line;
  logic [LW-1:0] spi_new_line;
  logic          st_next_line;
  logic          st_write_line;
  logic [LW-1:0] st_new_line;
  logic          spi_busy;
  logic          spi_overflow;
  logic [HW-1:0] head_row;

  int      checks   = 0;
  int      failures = 0;
  exp_op_t exp_q[$];
  exp_op_t sb_exp;

  always #5 clk = ~clk;

  p18_block_state_arbiter dut (
    .clk            (clk),
    .nRst           (nRst),
    .vactive        (vactive),
    .reset_state    (reset_state),
    .vid_next_line  (vid_next_line),
    .vid_write_line (vid_write_line),
    .vid_new_line   (vid_new_line),
    .spi_start      (spi_start),
    .spi_write_line (spi_write_line),
    .spi_shift_line (spi_shift_line),
    .spi_new_line   (spi_new_line),
    .st_next_line   (st_next_line),
    .st_write_line  (st_write_line),
    .st_new_line    (st_new_line),
    .spi_busy       (spi_busy),
    .spi_overflow   (spi_overflow),
    .head_row       (head_row)
  );

  // Storage-side scoreboard: video passes straight through, host ops leave in push order.
  always @(negedge clk) begin
    if (nRst) begin
      if (vid_next_line || vid_write_line) begin
        checks++;
        if (st_next_line !== vid_next_line || st_write_line !== vid_write_line ||
            st_new_line !== vid_new_line) begin
          failures++;
          $display("FAIL sb_video: got nx=%b wr=%b d=%h expected nx=%b wr=%b d=%h",
                   st_next_line, st_write_line, st_new_line,
                   vid_next_line, vid_write_line, vid_new_line);
        end
      end else if (st_next_line || st_write_line) begin
        if (exp_q.size() == 0) begin
          if (st_write_line) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_write: got data=%h expected no host write", st_new_line);
          end
        end else begin
          sb_exp = exp_q.pop_front();
          checks++;
          if (st_write_line !== sb_exp.wr || st_next_line !== sb_exp.sh ||
              (sb_exp.wr && st_new_line !== sb_exp.data)) begin
            failures++;
            $display("FAIL sb_host_op: got wr=%b sh=%b d=%h expected wr=%b sh=%b d=%h",
                     st_write_line, st_next_line, st_new_line,
                     sb_exp.wr, sb_exp.sh, sb_exp.data);
          end
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nRst = 1'b0; vactive = 1'b1; reset_state = 1'b0;
    vid_next_line = 1'b0; vid_write_line = 1'b0; vid_new_line = '0;
    spi_start = 1'b0; spi_write_line = 1'b0; spi_shift_line = 1'b0; spi_new_line = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({st_next_line, st_write_line} !== 2'b00 || st_new_line !== '0) begin
      failures++;
      $display("FAIL reset_st: got nx=%b wr=%b d=%h expected 0 0 0", st_next_line, st_write_line, st_new_line);
    end
    checks++;
    if (head_row !== 4'd0) begin failures++; $display("FAIL reset_head: got %0d expected 0", head_row); end
    checks++;
    if (spi_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", spi_busy); end
    checks++;
    if (spi_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", spi_overflow); end
    nRst = 1'b1;
  endtask

  task automatic test_window_issue();
    next_cyc();
    spi_write_line = 1'b1; spi_new_line = 13'h1ABC;
    exp_q.push_back('{1'b1, 1'b0, 13'h1ABC});
    @(negedge clk);
    checks++;
    if (st_write_line !== 1'b0) begin failures++; $display("FAIL hold_write: got %b expected 0", st_write_line); end
    next_cyc();
    spi_write_line = 1'b0; spi_shift_line = 1'b1; spi_new_line = '0;
    exp_q.push_back('{1'b0, 1'b1, 13'h0});
    @(negedge clk);
    checks++;
    if (st_next_line !== 1'b0) begin failures++; $display("FAIL hold_shift: got %b expected 0", st_next_line); end
    next_cyc();
    spi_shift_line = 1'b0;
    @(negedge clk);
    checks++;
    if (spi_busy !== 1'b1) begin failures++; $display("FAIL queued_busy: got %b expected 1", spi_busy); end
    next_cyc();
    vactive = 1'b0;
    @(negedge clk);
    checks++;
    if (st_write_line !== 1'b1 || st_next_line !== 1'b0 || st_new_line !== 13'h1ABC) begin
      failures++;
      $display("FAIL first_window_write: got wr=%b nx=%b d=%h expected 1 0 1abc", st_write_line, st_next_line, st_new_line);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (st_next_line !== 1'b1 || st_write_line !== 1'b0 || head_row !== 4'd0) begin
      failures++;
      $display("FAIL second_window_shift: got nx=%b wr=%b head=%0d expected 1 0 0", st_next_line, st_write_line, head_row);
    end
    next_cyc();
    vactive = 1'b1;
    @(negedge clk);
    checks++;
    if (head_row !== 4'd1 || spi_busy !== 1'b0) begin
      failures++;
      $display("FAIL after_issue: got head=%0d busy=%b expected 1 0", head_row, spi_busy);
    end
  endtask

  task automatic test_video_priority();
    next_cyc();
    spi_shift_line = 1'b1; spi_new_line = '0;
    exp_q.push_back('{1'b0, 1'b1, 13'h0});
    next_cyc();
    spi_shift_line = 1'b0; vactive = 1'b0; vid_next_line = 1'b1;
    @(negedge clk);
    checks++;
    if (st_next_line !== 1'b1 || spi_busy !== 1'b1) begin
      failures++;
      $display("FAIL video_stall: got nx=%b busy=%b expected 1 1", st_next_line, spi_busy);
    end
    next_cyc();
    vid_next_line = 1'b0;
    @(negedge clk);
    checks++;
    if (st_next_line !== 1'b1 || st_write_line !== 1'b0) begin
      failures++;
      $display("FAIL host_after_video: got nx=%b wr=%b expected 1 0", st_next_line, st_write_line);
    end
    next_cyc();
    vactive = 1'b1; vid_write_line = 1'b1; vid_new_line = 13'h0F0F;
    @(negedge clk);
    checks++;
    if (head_row !== 4'd3) begin failures++; $display("FAIL head_two_shifts: got %0d expected 3", head_row); end
    checks++;
    if (st_write_line !== 1'b1 || st_new_line !== 13'h0F0F) begin
      failures++;
      $display("FAIL video_write_blank: got wr=%b d=%h expected 1 0f0f", st_write_line, st_new_line);
    end
    next_cyc();
    vid_write_line = 1'b0;
    @(negedge clk);
    checks++;
    if (head_row !== 4'd3) begin failures++; $display("FAIL head_after_vwrite: got %0d expected 3", head_row); end
  endtask

  task automatic test_overflow();
    next_cyc();
    spi_write_line = 1'b1; spi_new_line = 13'h0111;
    exp_q.push_back('{1'b1, 1'b0, 13'h0111});
    next_cyc();
    spi_new_line = 13'h0222;
    exp_q.push_back('{1'b1, 1'b0, 13'h0222});
    next_cyc();
    spi_new_line = 13'h0333; spi_start = 1'b1;
    @(negedge clk);
    checks++;
    if (spi_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b expected 0", spi_overflow); end
    next_cyc();
    spi_write_line = 1'b0; spi_start = 1'b0;
    @(negedge clk);
    checks++;
    if (spi_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_with_start: got %b expected 1", spi_overflow); end
    next_cyc();
    spi_start = 1'b1;
    next_cyc();
    spi_start = 1'b0;
    @(negedge clk);
    checks++;
    if (spi_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", spi_overflow); end
    next_cyc();
    vactive = 1'b0; spi_write_line = 1'b1; spi_new_line = 13'h0444;
    exp_q.push_back('{1'b1, 1'b0, 13'h0444});
    @(negedge clk);
    checks++;
    if (st_write_line !== 1'b1 || st_new_line !== 13'h0111) begin
      failures++;
      $display("FAIL ovf_issue_a: got wr=%b d=%h expected 1 0111", st_write_line, st_new_line);
    end
    next_cyc();
    spi_write_line = 1'b0;
    @(negedge clk);
    checks++;
    if (st_new_line !== 13'h0222 || spi_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_issue_b: got d=%h ovf=%b expected 0222 0", st_new_line, spi_overflow);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (st_write_line !== 1'b1 || st_new_line !== 13'h0444) begin
      failures++;
      $display("FAIL full_push_pop: got wr=%b d=%h expected 1 0444", st_write_line, st_new_line);
    end
    next_cyc();
    vactive = 1'b1;
    @(negedge clk);
    checks++;
    if (st_write_line !== 1'b0 || spi_busy !== 1'b0 || spi_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_done: got wr=%b busy=%b ovf=%b expected 0 0 0", st_write_line, spi_busy, spi_overflow);
    end
  endtask

  task automatic test_realign();
    int cnt;
    next_cyc();
    vid_next_line = 1'b1;
    repeat (2) next_cyc();
    vid_next_line = 1'b0;
    @(negedge clk);
    checks++;
    if (head_row !== 4'd5) begin failures++; $display("FAIL realign_pre: got %0d expected 5", head_row); end
    next_cyc();
    cnt = 0;
    vactive = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (st_next_line) cnt++;
      next_cyc();
    end
    vactive = 1'b1;
    @(negedge clk);
    checks++;
    if (cnt != 10 || head_row !== 4'd0 || spi_busy !== 1'b0) begin
      failures++;
      $display("FAIL realign_full: got shifts=%0d head=%0d busy=%b expected 10 0 0", cnt, head_row, spi_busy);
    end
    next_cyc();
    vid_next_line = 1'b1;
    repeat (5) next_cyc();
    vid_next_line = 1'b0;
    vactive = 1'b0;
    repeat (4) next_cyc();
    vactive = 1'b1;
    @(negedge clk);
    checks++;
    if (head_row !== 4'd9) begin failures++; $display("FAIL realign_partial: got %0d expected 9", head_row); end
    next_cyc();
    cnt = 0;
    vactive = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (st_next_line) cnt++;
      next_cyc();
    end
    vactive = 1'b1;
    @(negedge clk);
    checks++;
    if (cnt != 6 || head_row !== 4'd0) begin
      failures++;
      $display("FAIL realign_resume: got shifts=%0d head=%0d expected 6 0", cnt, head_row);
    end
  endtask

  task automatic test_reset_state();
    int seen;
    next_cyc();
    vid_next_line = 1'b1;
    repeat (7) next_cyc();
    vid_next_line = 1'b0;
    spi_write_line = 1'b1; spi_new_line = 13'h0AAA;
    next_cyc();
    spi_write_line = 1'b0; spi_shift_line = 1'b1;
    next_cyc();
    spi_shift_line = 1'b0;
    @(negedge clk);
    checks++;
    if (head_row !== 4'd7 || spi_busy !== 1'b1) begin
      failures++;
      $display("FAIL rs_pre: got head=%0d busy=%b expected 7 1", head_row, spi_busy);
    end
    next_cyc();
    reset_state = 1'b1; spi_write_line = 1'b1; spi_new_line = 13'h1FFF;
    next_cyc();
    reset_state = 1'b0; spi_write_line = 1'b0;
    @(negedge clk);
    checks++;
    if (head_row !== 4'd0 || spi_busy !== 1'b0 || spi_overflow !== 1'b0) begin
      failures++;
      $display("FAIL rs_clear: got head=%0d busy=%b ovf=%b expected 0 0 0", head_row, spi_busy, spi_overflow);
    end
    next_cyc();
    seen = 0;
    vactive = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (st_next_line || st_write_line) seen++;
      next_cyc();
    end
    vactive = 1'b1;
    checks++;
    if (seen != 0) begin failures++; $display("FAIL rs_no_issue: got %0d ops expected 0", seen); end
  endtask

  task automatic test_async_reset();
    next_cyc();
    spi_shift_line = 1'b1; spi_new_line = '0;
    exp_q.push_back('{1'b0, 1'b1, 13'h0});
    next_cyc();
    spi_shift_line = 1'b0; spi_write_line = 1'b1; spi_new_line = 13'h1234;
    exp_q.push_back('{1'b1, 1'b0, 13'h1234});
    next_cyc();
    spi_write_line = 1'b0; vactive = 1'b0;
    @(negedge clk);
    checks++;
    if (st_next_line !== 1'b1) begin failures++; $display("FAIL nrst_pre_issue: got %b expected 1", st_next_line); end
    next_cyc();
    nRst = 1'b0; vid_next_line = 1'b1;
    #1;
    checks++;
    if ({st_next_line, st_write_line} !== 2'b00 || st_new_line !== '0 || head_row !== 4'd0 ||
        spi_busy !== 1'b0 || spi_overflow !== 1'b0) begin
      failures++;
      $display("FAIL nrst_async: got nx=%b wr=%b d=%h head=%0d busy=%b ovf=%b expected all 0",
               st_next_line, st_write_line, st_new_line, head_row, spi_busy, spi_overflow);
    end
    exp_q.delete();
    vid_next_line = 1'b0; vactive = 1'b1;
    next_cyc();
    nRst = 1'b1;
    @(negedge clk);
    checks++;
    if (spi_busy !== 1'b0 || head_row !== 4'd0) begin
      failures++;
      $display("FAIL nrst_release: got busy=%b head=%0d expected 0 0", spi_busy, head_row);
    end
  endtask

  task automatic test_combined();
    next_cyc();
    spi_write_line = 1'b1; spi_shift_line = 1'b1; spi_new_line = 13'h1555;
    exp_q.push_back('{1'b1, 1'b1, 13'h1555});
    next_cyc();
    spi_write_line = 1'b0; spi_shift_line = 1'b0; vactive = 1'b0;
    @(negedge clk);
    checks++;
    if (st_write_line !== 1'b1 || st_next_line !== 1'b1 || st_new_line !== 13'h1555) begin
      failures++;
      $display("FAIL combined_op: got wr=%b nx=%b d=%h expected 1 1 1555", st_write_line, st_next_line, st_new_line);
    end
    next_cyc();
    vactive = 1'b1;
    @(negedge clk);
    checks++;
    if (head_row !== 4'd1) begin failures++; $display("FAIL combined_head: got %0d expected 1", head_row); end
  endtask

  initial begin
    test_reset();
    test_window_issue();
    test_video_priority();
    test_overflow();
    test_realign();
    test_reset_state();
    test_async_reset();
    test_combined();
    next_cyc();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending ops expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/p18_block_state_arbiter.md
Name: p18_block_state_arbiter

Overview:
Shares the block-state line storage between two requesters: the blocks painter (video) and the SPI command controller (host).
- Video traffic passes through with zero latency and absolute priority.
- Host write/shift ops are queued and issued only during vertical blanking.
- Sits between p18_blocks_painter / p18_spi_ctrl and p18_block_state, replacing the plain OR/mux at the storage inputs.
- Tracks the storage rotation and realigns it so video always sees row 0 at the head at frame start.

Parameters:
NUM_ROWS, 15, rows in the storage rotation (pointer modulus)
LINE_WIDTH, 13, bits per block line
FIFO_DEPTH, 2, host op queue entries (power of 2, >=2)

Ports:
clk  in  1  system clock
nRst  in  1  reset; asynchronous, active-low
vactive  in  1  vertical active display; 0 = arbitration window open
reset_state  in  1  game-logic storage reset pulse
vid_next_line  in  1  video shift request
vid_write_line  in  1  video write request
vid_new_line  in  LINE_WIDTH  video write data
spi_start  in  1  host transaction start (clears overflow)
spi_write_line  in  1  host write request
spi_shift_line  in  1  host shift request
spi_new_line  in  LINE_WIDTH  host write data
st_next_line  out  1  to storage: rotate
st_write_line  out  1  to storage: write head line
st_new_line  out  LINE_WIDTH  to storage: write data
spi_busy  out  1  queue non-empty or FSM not IDLE
spi_overflow  out  1  sticky: host op dropped because queue full
head_row  out  $clog2(NUM_ROWS)  row index currently at storage head

Behaviour:
- Reset (nRst=0, async): FIFO empty, head_row=0, FSM=IDLE, all outputs 0.
- Host enqueue:
  - Any cycle with spi_write_line|spi_shift_line pushes op {wr,sh,data}; both set = one combined op.
  - Push when full: op dropped, spi_overflow<=1.
  - spi_overflow clears on spi_start; a spi_start in the same cycle as an overflow leaves it set.
- Video path:
  - Combinational: if vid_next_line|vid_write_line, st_* = vid_* in that cycle, in any state and any window.
  - The FSM issues nothing that cycle; the pending host op stays at the FIFO head.
- FSM states (host issue):
  - IDLE -> ISSUE when window open & FIFO non-empty.
  - IDLE -> REALIGN when window open & FIFO empty & head_row!=0.
  - ISSUE: each non-stalled cycle pops the head op and drives st_write_line=wr, st_next_line=sh, st_new_line=data. Exits to IDLE when FIFO empty after pop, or when window closes.
  - REALIGN: drives st_next_line=1 each non-stalled cycle until head_row==0, then goes to IDLE. Window close aborts to IDLE; realign resumes next window.
  - Ops are single-cycle, so a window close never splits an op. An op popped in the last open cycle completes.
- Latency: a host op pushed at cycle t issues no earlier than t+1 (FIFO registered). Push and pop in the same cycle are allowed, including when full: the pop frees the slot, so no overflow.
- head_row: increments mod NUM_ROWS on every st_next_line regardless of source. It wraps NUM_ROWS-1 -> 0.
- reset_state: synchronously clears head_row to 0, flushes the FIFO and forces IDLE. It takes priority over a simultaneous push, which is discarded without setting overflow.

Decomposition:
- Shared package p18_pkg: LINE_WIDTH, NUM_ROWS, host-op struct {wr, sh, data}, FSM state enum {IDLE, ISSUE, REALIGN}.
- Sub-module p18_op_fifo: parameterized sync FIFO with push/pop/full/empty, flush input and async active-low reset.

Test Plan:
- During vactive=1, host pushes write(0x1ABC) + shift → nothing reaches storage. When vactive drops, write issues at first window cycle, shift next cycle; head_row 0→1; spi_busy falls after the pop.
- Window open, FIFO holds shift; vid_next_line asserted same cycle → st_next_line from video only. Host shift issues next cycle; head_row advances by 2 total.
- 3 host ops pushed back-to-back with vactive=1, depth 2 → spi_overflow=1, only 2 ops issued in window; spi_start clears flag.
- head_row=5, FIFO empty, window opens for 20 cycles → exactly 10 realign shifts, head_row=0, FSM IDLE. With only 4 open cycles: head_row=9, then 6 shifts next window.
- reset_state pulse with 2 queued ops and head_row=7 → FIFO empty, head_row=0, no ops issued. nRst low mid-ISSUE → all outputs 0 immediately.
- Combined write+shift host op → st_write_line and st_next_line both high in one cycle with the correct data; head_row increments once.
